// File: rtl/npu_pkg.sv
// Shared NPU definitions: data widths, function-select codes and the
// sigmoid issue sequencer state encoding.
package npu_pkg;

  localparam int unsigned ACC_W = 48;
  localparam int unsigned ACT_W = 16;

  localparam logic [1:0] FN_TANH   = 2'd0;
  localparam logic [1:0] FN_LINEAR = 2'd1;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_ISSUE,
    ST_DRAIN,
    ST_DONE
  } issue_state_t;

endpackage

// File: rtl/npu_sigmoid_tag_pipe.sv
// Valid-tag shift register that follows operands through the fixed-latency
// sigmoid unit; the tail bit marks a valid activation in the current cycle.
module npu_sigmoid_tag_pipe #(
  parameter int unsigned DEPTH = 2
) (
  input  logic clk,
  input  logic rst_n,
  input  logic push,
  output logic tail,
  output logic drained
);

  logic [DEPTH-1:0] pipe;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) pipe <= '0;
    else        pipe <= {pipe[DEPTH-2:0], push};
  end

  assign tail = pipe[DEPTH-1];

  // drained: every tag left sits in the last two stages, so the final
  // retirement happens within one cycle of leaving the drain state.
  generate
    if (DEPTH > 2) begin : g_deep
      assign drained = ~|pipe[DEPTH-3:0];
    end else begin : g_short
      assign drained = 1'b1;
    end
  endgenerate

endmodule

// File: rtl/npu_sigmoid_issue.sv
// Issue/retire sequencer feeding PE accumulator results in index order to the
// sigmoid unit and routing activations to the feedback or output FIFO.
module npu_sigmoid_issue
  import npu_pkg::*;
#(
  parameter int unsigned NUM_PE      = 8,
  parameter int unsigned SIG_LATENCY = 1
) (
  input  logic                    CLK,
  input  logic                    npu_rst_n,
  input  logic                    sched_start,
  input  logic [4:0]              sched_neuron_cnt,
  input  logic [1:0]              sched_func_sel,
  input  logic                    sched_last_layer,
  input  logic [NUM_PE-1:0]       pe_acc_valid,
  input  logic [NUM_PE*ACC_W-1:0] pe_acc_data,
  output logic [NUM_PE-1:0]       pe_acc_ack,
  output logic [ACC_W-1:0]        npu_sigmoid_din,
  output logic [1:0]              npu_sched_sigmoid_function_sel,
  input  logic [ACT_W-1:0]        npu_sigmoid_dout,
  input  logic                    sig_fifo_afull,
  input  logic                    out_fifo_afull,
  output logic                    sig_fifo_wr_en,
  output logic [ACT_W-1:0]        sig_fifo_din,
  output logic                    out_fifo_wr_en,
  output logic [ACT_W-1:0]        out_fifo_din,
  output logic                    layer_done,
  output logic                    busy
);

  localparam int unsigned IDX_W = (NUM_PE > 1) ? $clog2(NUM_PE) : 1;

  issue_state_t     state, state_nxt;
  logic [IDX_W-1:0] idx, idx_nxt;
  logic [4:0]       cnt;
  logic             last_layer;
  logic             fire;
  logic             dest_afull;
  logic             idx_last;
  logic             tail;
  logic             drained;

  assign dest_afull = last_layer ? out_fifo_afull : sig_fifo_afull;
  assign idx_last   = (5'(idx) == cnt - 5'd1);

  always_comb begin
    state_nxt  = state;
    idx_nxt    = idx;
    fire       = 1'b0;
    pe_acc_ack = '0;
    case (state)
      ST_IDLE: begin
        if (sched_start) begin
          idx_nxt   = '0;
          state_nxt = (sched_neuron_cnt == 5'd0) ? ST_DONE : ST_ISSUE;
        end
      end
      ST_ISSUE: begin
        if (pe_acc_valid[idx] && !dest_afull) begin
          fire            = 1'b1;
          pe_acc_ack[idx] = 1'b1;
          if (idx_last) state_nxt = ST_DRAIN;
          else          idx_nxt   = idx + 1'b1;
        end
      end
      ST_DRAIN: begin
        if (drained) state_nxt = ST_DONE;
      end
      ST_DONE:  state_nxt = ST_IDLE;
      default:  state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge CLK or negedge npu_rst_n) begin
    if (!npu_rst_n) begin
      state                          <= ST_IDLE;
      idx                            <= '0;
      cnt                            <= '0;
      last_layer                     <= 1'b0;
      npu_sched_sigmoid_function_sel <= FN_TANH;
      npu_sigmoid_din                <= '0;
      layer_done                     <= 1'b0;
    end else begin
      state      <= state_nxt;
      idx        <= idx_nxt;
      // DONE is entered in the cycle of the final write, so the registered
      // pulse lands one cycle after it.
      layer_done <= (state == ST_DONE);
      if (state == ST_IDLE && sched_start) begin
        cnt <= (sched_neuron_cnt > 5'(NUM_PE)) ? 5'(NUM_PE) : sched_neuron_cnt;
        npu_sched_sigmoid_function_sel <= sched_func_sel;
        last_layer                     <= sched_last_layer;
      end
      if (fire) npu_sigmoid_din <= pe_acc_data[ACC_W*int'(idx) +: ACC_W];
    end
  end

  npu_sigmoid_tag_pipe #(
    .DEPTH (SIG_LATENCY + 1)
  ) u_tag_pipe (
    .clk     (CLK),
    .rst_n   (npu_rst_n),
    .push    (fire),
    .tail    (tail),
    .drained (drained)
  );

  assign sig_fifo_wr_en = tail & ~last_layer;
  assign out_fifo_wr_en = tail &  last_layer;
  assign sig_fifo_din   = sig_fifo_wr_en ? npu_sigmoid_dout : '0;
  assign out_fifo_din   = out_fifo_wr_en ? npu_sigmoid_dout : '0;
  assign busy           = (state != ST_IDLE);

endmodule

// File: tb/tb_npu_sigmoid_issue.sv
// Bench for npu_sigmoid_issue: a behavioural sigmoid unit plus a scoreboard
// model predicting acks, operand, writes, busy and layer_done every cycle.
module tb_npu_sigmoid_issue;

  localparam int NUM_PE = 8;
  localparam int LAT    = 1;

  logic                 clk = 1'b0;
  logic                 rst_n;
  logic                 sched_start;
  logic [4:0]           sched_cnt;
  logic [1:0]           sched_func;
  logic                 sched_last;
  logic [NUM_PE-1:0]    valid;
  logic [NUM_PE*48-1:0] pe_data;
  logic [NUM_PE-1:0]    ack;
  logic [47:0]          din;
  logic [1:0]           fsel;
  logic [15:0]          sig_dout;
  logic                 sig_afull, out_afull;
  logic                 sig_wr, out_wr;
  logic [15:0]          sig_din, out_din;
  logic                 layer_done, busy;

  int cyc = 0;
  int cmp_checks = 0, cmp_fails = 0;
  int dir_checks = 0, dir_fails = 0;

  int wr_cyc[$], wr_val[$], wr_dst[$];
  int ack_cyc[$], ack_idx[$];
  int done_cyc[$];

  initial forever #5 clk = ~clk;
  always_ff @(posedge clk) cyc <= cyc + 1;

  npu_sigmoid_issue #(
    .NUM_PE      (NUM_PE),
    .SIG_LATENCY (LAT)
  ) dut (
    .CLK                            (clk),
    .npu_rst_n                      (rst_n),
    .sched_start                    (sched_start),
    .sched_neuron_cnt               (sched_cnt),
    .sched_func_sel                 (sched_func),
    .sched_last_layer               (sched_last),
    .pe_acc_valid                   (valid),
    .pe_acc_data                    (pe_data),
    .pe_acc_ack                     (ack),
    .npu_sigmoid_din                (din),
    .npu_sched_sigmoid_function_sel (fsel),
    .npu_sigmoid_dout               (sig_dout),
    .sig_fifo_afull                 (sig_afull),
    .out_fifo_afull                 (out_afull),
    .sig_fifo_wr_en                 (sig_wr),
    .sig_fifo_din                   (sig_din),
    .out_fifo_wr_en                 (out_wr),
    .out_fifo_din                   (out_din),
    .layer_done                     (layer_done),
    .busy                           (busy)
  );

  // Sigmoid unit stand-in: linear = acc >>> 7, tanh = hard tanh (acc >>> 9
  // clamped to +-1.0 = +-0x80), reserved codes give zero.
  function automatic logic [15:0] sig_fn(input logic [47:0] x, input logic [1:0] fs);
    longint sx, t;
    sx = longint'($signed(x));
    case (fs)
      2'd1: begin
        t = sx >>> 7;
        return t[15:0];
      end
      2'd0: begin
        t = sx >>> 9;
        if (t > 128)  t = 128;
        if (t < -128) t = -128;
        return t[15:0];
      end
      default: return 16'h0000;
    endcase
  endfunction

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) sig_dout <= '0;
    else        sig_dout <= sig_fn(din, fsel);
  end

  task automatic cchk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    cmp_checks++;
    if (act !== exp) begin
      cmp_fails++;
      $display("FAIL %s cyc=%0d actual=%0h required=%0h", nm, cyc, act, exp);
    end
  endtask

  task automatic dchk(input string nm, input int act, input int exp);
    dir_checks++;
    if (act != exp) begin
      dir_fails++;
      $display("FAIL %s actual=%0d required=%0d", nm, act, exp);
    end
  endtask

  typedef struct {
    int          due;
    logic [15:0] val;
    bit          dst;
  } wr_t;

  wr_t         wq[$];
  bit          m_active = 1'b0;
  int          m_open = 0, m_next = 0, m_count = 0, m_done_due = 0;
  bit          m_dst = 1'b0;
  logic [1:0]  m_func = 2'd0;
  logic [1:0]  m_fsel = 2'd0;
  logic [47:0] m_din = '0;

  always @(negedge clk) begin : cmp
    logic [NUM_PE-1:0] e_ack;
    bit                e_wr, e_busy, e_done, af, idle;
    wr_t               w, h;
    if (!rst_n) begin
      cchk("rst_ack", 64'(ack), 64'd0);
      cchk("rst_din", 64'(din), 64'd0);
      cchk("rst_fsel", 64'(fsel), 64'd0);
      cchk("rst_wr_en", 64'({sig_wr, out_wr}), 64'd0);
      cchk("rst_fifo_din", 64'({sig_din, out_din}), 64'd0);
      cchk("rst_done_busy", 64'({layer_done, busy}), 64'd0);
      wq.delete();
      m_active = 1'b0; m_next = 0; m_count = 0; m_done_due = 0;
      m_din = '0; m_fsel = 2'd0;
    end else begin
      e_busy = m_active && cyc >= m_open && cyc < m_done_due;
      e_done = m_active && cyc == m_done_due;
      af     = m_dst ? out_afull : sig_afull;
      e_ack  = '0;
      if (m_active && cyc >= m_open && m_next < m_count && valid[m_next] && !af)
        e_ack[m_next] = 1'b1;
      e_wr = (wq.size() > 0) && (wq[0].due == cyc);
      if (e_wr) h = wq[0];
      else begin h.due = 0; h.val = '0; h.dst = 1'b0; end

      cchk("ack", 64'(ack), 64'(e_ack));
      cchk("din", 64'(din), 64'(m_din));
      cchk("func_sel", 64'(fsel), 64'(m_fsel));
      cchk("busy", 64'(busy), 64'(e_busy));
      cchk("layer_done", 64'(layer_done), 64'(e_done));
      cchk("sig_wr_en", 64'(sig_wr), 64'(e_wr && !h.dst));
      cchk("out_wr_en", 64'(out_wr), 64'(e_wr && h.dst));
      if (e_wr && !h.dst) cchk("sig_fifo_din", 64'(sig_din), 64'(h.val));
      if (e_wr && h.dst)  cchk("out_fifo_din", 64'(out_din), 64'(h.val));

      for (int i = 0; i < NUM_PE; i++)
        if (ack[i]) begin ack_cyc.push_back(cyc); ack_idx.push_back(i); end
      if (sig_wr) begin wr_cyc.push_back(cyc); wr_val.push_back(int'(sig_din)); wr_dst.push_back(0); end
      if (out_wr) begin wr_cyc.push_back(cyc); wr_val.push_back(int'(out_din)); wr_dst.push_back(1); end
      if (layer_done) done_cyc.push_back(cyc);

      if (e_ack != '0) begin
        w.due = cyc + 1 + LAT;
        w.val = sig_fn(pe_data[m_next*48 +: 48], m_func);
        w.dst = m_dst;
        wq.push_back(w);
        m_din = pe_data[m_next*48 +: 48];
        m_next++;
      end
      if (e_wr) begin
        void'(wq.pop_front());
        if (m_next == m_count && wq.size() == 0) m_done_due = cyc + 1;
      end
      idle = !m_active || cyc >= m_done_due;
      if (idle && sched_start) begin
        m_active   = 1'b1;
        m_open     = cyc + 1;
        m_count    = (int'(sched_cnt) > NUM_PE) ? NUM_PE : int'(sched_cnt);
        m_next     = 0;
        m_dst      = sched_last;
        m_func     = sched_func;
        m_fsel     = sched_func;
        m_done_due = (m_count == 0) ? cyc + 2 : 32'h7fff_ffff;
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_pe(input int i, input logic [47:0] v);
    pe_data[i*48 +: 48] = v;
  endtask

  task automatic start_layer(input int cnt, input logic [1:0] fs, input logic last);
    sched_start = 1'b1;
    sched_cnt   = 5'(cnt);
    sched_func  = fs;
    sched_last  = last;
  endtask

  task automatic run_linear3();
    int s, b, bd;
    tick();
    s = cyc; b = wr_cyc.size(); bd = done_cyc.size();
    set_pe(0, 48'h0000_0000_1000);
    set_pe(1, 48'h0000_0000_2000);
    set_pe(2, 48'hFFFF_FFFF_F000);
    valid = 8'h07;
    start_layer(3, 2'd1, 1'b0);
    tick();
    sched_start = 1'b0;
    repeat (8) tick();
    valid = '0;
    dchk("lin_write_count", wr_cyc.size() - b, 3);
    if (wr_cyc.size() >= b + 3) begin
      dchk("lin_w0_val", wr_val[b],     'h0020);
      dchk("lin_w1_val", wr_val[b + 1], 'h0040);
      dchk("lin_w2_val", wr_val[b + 2], 'hFFE0);
      dchk("lin_w0_cyc", wr_cyc[b],     s + 3);
      dchk("lin_w2_cyc", wr_cyc[b + 2], s + 5);
      dchk("lin_dest",   wr_dst[b] + wr_dst[b + 1] + wr_dst[b + 2], 0);
    end
    dchk("lin_done_count", done_cyc.size() - bd, 1);
    if (done_cyc.size() > bd) dchk("lin_done_cyc", done_cyc[bd], s + 6);
  endtask

  initial begin : main
    int s, b, ba, bd, n;
    logic [63:0] r;
    longint      lv;
    rst_n = 1'b0; sched_start = 1'b0; sched_cnt = '0; sched_func = '0;
    sched_last = 1'b0; valid = '0; pe_data = '0; sig_afull = 1'b0; out_afull = 1'b0;
    repeat (3) tick();
    rst_n = 1'b1;
    repeat (2) tick();

    run_linear3();

    // tanh saturation into the output FIFO
    tick();
    s = cyc; b = wr_cyc.size();
    set_pe(0, 48'h0000_0001_0000);
    set_pe(1, 48'hFFFF_FFFE_0000);
    valid = 8'h03;
    start_layer(2, 2'd0, 1'b1);
    tick();
    sched_start = 1'b0;
    repeat (8) tick();
    valid = '0;
    dchk("tanh_write_count", wr_cyc.size() - b, 2);
    if (wr_cyc.size() >= b + 2) begin
      dchk("tanh_w0_val", wr_val[b], 'h0080);
      dchk("tanh_w1_val", wr_val[b + 1], 'hFF80);
      dchk("tanh_dest", wr_dst[b] + wr_dst[b + 1], 2);
    end

    // in-order stall: PE1 ready first, PE0 five cycles later
    tick();
    s = cyc; ba = ack_cyc.size();
    valid = 8'h02;
    start_layer(2, 2'd1, 1'b0);
    tick();
    sched_start = 1'b0;
    repeat (4) tick();
    valid = 8'h03;
    repeat (8) tick();
    valid = '0;
    dchk("stall_ack_count", ack_cyc.size() - ba, 2);
    if (ack_cyc.size() >= ba + 2) begin
      dchk("stall_first_idx", ack_idx[ba], 0);
      dchk("stall_first_cyc", ack_cyc[ba], s + 5);
      dchk("stall_second_idx", ack_idx[ba + 1], 1);
    end

    // backpressure: sig afull high for cycles s+3..s+6
    tick();
    s = cyc; b = wr_cyc.size(); ba = ack_cyc.size();
    for (int i = 0; i < NUM_PE; i++) set_pe(i, 48'((i + 1) * 'h80));
    valid = '1;
    start_layer(8, 2'd1, 1'b0);
    tick();
    sched_start = 1'b0;
    tick();
    tick();
    sig_afull = 1'b1;
    repeat (4) tick();
    sig_afull = 1'b0;
    repeat (14) tick();
    valid = '0;
    dchk("bp_ack_count", ack_cyc.size() - ba, 8);
    n = 0;
    for (int i = ba; i < ack_cyc.size(); i++) if (ack_cyc[i] >= s + 3 && ack_cyc[i] <= s + 6) n++;
    dchk("bp_no_issue_in_afull", n, 0);
    dchk("bp_write_count", wr_cyc.size() - b, 8);
    n = 0;
    for (int i = b; i < wr_cyc.size(); i++) if (wr_cyc[i] >= s + 3 && wr_cyc[i] <= s + 6) n++;
    dchk("bp_inflight_writes", n, 2);

    // count 0
    tick();
    s = cyc; b = wr_cyc.size(); ba = ack_cyc.size(); bd = done_cyc.size();
    start_layer(0, 2'd1, 1'b0);
    tick();
    sched_start = 1'b0;
    repeat (4) tick();
    dchk("cnt0_done_count", done_cyc.size() - bd, 1);
    if (done_cyc.size() > bd) dchk("cnt0_done_cyc", done_cyc[bd], s + 2);
    dchk("cnt0_no_activity", (wr_cyc.size() - b) + (ack_cyc.size() - ba), 0);

    // second start during ISSUE is ignored
    tick();
    b = wr_cyc.size(); ba = ack_cyc.size();
    valid = '0;
    start_layer(3, 2'd1, 1'b0);
    tick();
    sched_start = 1'b0;
    tick();
    start_layer(1, 2'd0, 1'b1);
    tick();
    sched_start = 1'b0;
    valid = '1;
    repeat (10) tick();
    valid = '0;
    dchk("busy_start_ack_count", ack_cyc.size() - ba, 3);
    dchk("busy_start_write_count", wr_cyc.size() - b, 3);
    n = 0;
    for (int i = b; i < wr_cyc.size(); i++) n += wr_dst[i];
    dchk("busy_start_out_untouched", n, 0);

    // reset one cycle after an issue
    tick();
    b = wr_cyc.size(); bd = done_cyc.size();
    valid = '1;
    start_layer(4, 2'd1, 1'b0);
    tick();
    sched_start = 1'b0;
    tick();
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    valid = '0;
    repeat (6) tick();
    dchk("rst_no_writes", wr_cyc.size() - b, 0);
    dchk("rst_no_done", done_cyc.size() - bd, 0);
    run_linear3();

    // randomized traffic against the scoreboard
    for (int c = 0; c < 3000; c++) begin
      tick();
      for (int i = 0; i < NUM_PE; i++) begin
        valid[i] = ($urandom_range(0, 9) < 7);
        if ($urandom_range(0, 1) == 0) begin
          r = {$urandom(), $urandom()};
          set_pe(i, r[47:0]);
        end else begin
          lv = longint'(int'($urandom_range(0, 262143)) - 131072);
          set_pe(i, lv[47:0]);
        end
      end
      sig_afull   = ($urandom_range(0, 9) == 0);
      out_afull   = ($urandom_range(0, 9) == 0);
      sched_start = ($urandom_range(0, 7) == 0);
      sched_cnt   = 5'($urandom_range(0, 12));
      sched_func  = 2'($urandom_range(0, 3));
      sched_last  = 1'($urandom_range(0, 1));
      rst_n       = ($urandom_range(0, 499) != 0);
    end
    tick();
    rst_n = 1'b1; sched_start = 1'b0; valid = '1; sig_afull = 1'b0; out_afull = 1'b0;
    repeat (40) tick();

    $display("TB_RESULT checks=%0d failures=%0d", cmp_checks + dir_checks, cmp_fails + dir_fails);
    $finish;
  end

endmodule
